// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C command front end.
//   - default address/data widths of a command beat
//   - arbiter state encoding
//   - bit offsets of the {addr, data} fields inside an AXI-Stream tdata beat
package i2c_pkg;

    localparam int unsigned I2C_ADDR_WIDTH = 7;
    localparam int unsigned I2C_DATA_WIDTH = 8;

    // Data byte sits in the low bits of tdata, address directly above it.
    localparam int unsigned TDATA_DATA_LSB = 0;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    // Address field offset for a given data width.
    function automatic int unsigned tdata_addr_lsb(input int unsigned data_width);
        return TDATA_DATA_LSB + data_width;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, arst : clock and synchronous active-high reset
//   request   : per-port request
//   advance   : a grant was consumed this cycle; rotate priority
//   grant     : one-hot grant, combinational from request and priority
module rr_arb2 (
    input  logic       clk,
    input  logic       arst,
    input  logic [1:0] request,
    input  logic       advance,
    output logic [1:0] grant
);

    // 0: port 0 wins a tie, 1: port 1 wins a tie
    logic prio;

    always_comb begin
        grant = 2'b00;
        case (request)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // After granting port 0, port 1 gets priority and vice versa.
    always_ff @(posedge clk) begin
        if (arst) begin
            prio <= 1'b0;
        end else if (advance) begin
            prio <= grant[0];
        end
    end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Two-requester AXI-Stream front end for the shared I2C write engine.
// Accepts {addr, data} beats on s0/s1, arbitrates round-robin, launches one
// engine transaction per beat and reports done or timeout.
//   clk, arst           : clock, synchronous active-high reset
//   s0_*, s1_*          : AXI-Stream command slaves (tready only high in IDLE)
//   i2c_start           : one-cycle launch pulse
//   i2c_addr, i2c_data  : command held for the engine until the next grant
//   i2c_ready           : engine idle
//   done, err           : one-cycle completion / timeout pulses
//   grant_id            : requester of the current/last transaction
module i2c_req_arbiter
    import i2c_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = I2C_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = I2C_DATA_WIDTH,
    parameter int unsigned ACK_WAIT   = 4,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                           clk,
    input  logic                           arst,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] s0_tdata,
    input  logic                           s0_tvalid,
    output logic                           s0_tready,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] s1_tdata,
    input  logic                           s1_tvalid,
    output logic                           s1_tready,
    output logic                           i2c_start,
    output logic [ADDR_WIDTH-1:0]          i2c_addr,
    output logic [DATA_WIDTH-1:0]          i2c_data,
    input  logic                           i2c_ready,
    output logic                           done,
    output logic                           err,
    output logic                           grant_id
);

    localparam int unsigned TDATA_W  = ADDR_WIDTH + DATA_WIDTH;
    localparam int unsigned ADDR_LSB = tdata_addr_lsb(DATA_WIDTH);
    localparam int unsigned CNT_MAX  = (ACK_WAIT > TIMEOUT) ? ACK_WAIT : TIMEOUT;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_inc;
    logic [1:0]         request;
    logic [1:0]         grant;
    logic               accept;
    logic [TDATA_W-1:0] sel_tdata;

    assign request = {s1_tvalid, s0_tvalid};

    // Handshake only in IDLE with the engine free; masked during reset so
    // no beat is consumed while the FSM is being cleared.
    assign accept    = (state == IDLE) && i2c_ready && !arst && (|request);
    assign s0_tready = accept & grant[0];
    assign s1_tready = accept & grant[1];

    assign sel_tdata = grant[1] ? s1_tdata : s0_tdata;

    // Saturating increment so a long hang never wraps back to a small count.
    assign cnt_inc = (cnt == CNT_W'(CNT_MAX)) ? cnt : cnt + CNT_W'(1);

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .arst    (arst),
        .request (request),
        .advance (accept),
        .grant   (grant)
    );

    // Transaction sequencer with registered pulse outputs.
    always_ff @(posedge clk) begin
        if (arst) begin
            state     <= IDLE;
            cnt       <= '0;
            i2c_start <= 1'b0;
            i2c_addr  <= '0;
            i2c_data  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            grant_id  <= 1'b0;
        end else begin
            i2c_start <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        i2c_addr  <= sel_tdata[ADDR_LSB +: ADDR_WIDTH];
                        i2c_data  <= sel_tdata[TDATA_DATA_LSB +: DATA_WIDTH];
                        grant_id  <= grant[1];
                        i2c_start <= 1'b1;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    cnt   <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // Engine must acknowledge the start by dropping ready.
                    if (!i2c_ready) begin
                        cnt   <= '0;
                        state <= WAIT_DONE;
                    end else if (cnt == CNT_W'(ACK_WAIT - 1)) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                WAIT_DONE: begin
                    // Completion wins over a timeout landing on the same cycle.
                    if (i2c_ready) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Bench for i2c_req_arbiter: per-cycle vector table for single command and
// contention, hand sequences for stall, hang, reset mid-flight and busy idle.
// The downstream engine is a behavioural model with a programmable busy length.
module tb_i2c_req_arbiter;

    localparam int unsigned AW       = 7;
    localparam int unsigned DW       = 8;
    localparam int unsigned ACK_WAIT = 4;
    localparam int unsigned TIMEOUT  = 1024;

    logic          clk = 1'b0;
    logic          arst;
    logic [AW+DW-1:0] s0_tdata, s1_tdata;
    logic          s0_tvalid, s1_tvalid;
    logic          s0_tready, s1_tready;
    logic          i2c_start;
    logic [AW-1:0] i2c_addr;
    logic [DW-1:0] i2c_data;
    logic          i2c_ready;
    logic          done, err, grant_id;

    always #5 clk = ~clk;

    i2c_req_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .ACK_WAIT   (ACK_WAIT),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk       (clk),
        .arst      (arst),
        .s0_tdata  (s0_tdata),
        .s0_tvalid (s0_tvalid),
        .s0_tready (s0_tready),
        .s1_tdata  (s1_tdata),
        .s1_tvalid (s1_tvalid),
        .s1_tready (s1_tready),
        .i2c_start (i2c_start),
        .i2c_addr  (i2c_addr),
        .i2c_data  (i2c_data),
        .i2c_ready (i2c_ready),
        .done      (done),
        .err       (err),
        .grant_id  (grant_id)
    );

    // Behavioural engine: ready drops for busy_len cycles after a start.
    int   busy_len   = 2;
    int   busy_left  = 0;
    logic stall      = 1'b0;
    logic force_busy = 1'b0;

    always @(posedge clk) begin
        if (i2c_start && !stall) busy_left <= busy_len;
        else if (busy_left > 0)  busy_left <= busy_left - 1;
    end
    assign i2c_ready = !force_busy && (busy_left == 0);

    typedef struct packed {
        logic          arst;
        logic          v0;
        logic [14:0]   d0;
        logic          v1;
        logic [14:0]   d1;
    } vin_t;

    typedef struct packed {
        logic        t0;
        logic        t1;
        logic        start;
        logic        dn;
        logic        er;
        logic        gid;
        logic [6:0]  addr;
        logic [7:0]  data;
    } vout_t;

    typedef struct packed {
        vin_t  in;
        vout_t exp;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vout_t sample();
        vout_t o;
        o.t0 = s0_tready; o.t1 = s1_tready; o.start = i2c_start;
        o.dn = done; o.er = err; o.gid = grant_id;
        o.addr = i2c_addr; o.data = i2c_data;
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic a, input logic v0, input logic [14:0] d0,
                       input logic v1, input logic [14:0] d1,
                       input logic t0, input logic t1, input logic st,
                       input logic dn, input logic er, input logic gid,
                       input logic [6:0] ad, input logic [7:0] da);
        vec_t v;
        v.in.arst = a; v.in.v0 = v0; v.in.d0 = d0; v.in.v1 = v1; v.in.d1 = d1;
        v.exp.t0 = t0; v.exp.t1 = t1; v.exp.start = st; v.exp.dn = dn;
        v.exp.er = er; v.exp.gid = gid; v.exp.addr = ad; v.exp.data = da;
        vecs.push_back(v);
    endtask

    task automatic wait_done(input string name, input logic exp_gid);
        logic seen;
        logic g;
        seen = 1'b0;
        g    = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk); #1;
            if (done) begin
                seen = 1'b1;
                g    = grant_id;
            end
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        check({name, "_gid"}, 32'(g), 32'(exp_gid));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int    bad;
        vout_t o;

        arst = 1'b1; s0_tvalid = 1'b1; s0_tdata = {7'h50, 8'hA5};
        s1_tvalid = 1'b0; s1_tdata = '0;

        // Reset state, with a valid beat pending that must not be taken.
        repeat (3) @(negedge clk);
        #1 check("reset_state", 32'(sample()), 32'd0);

        // Single command, then reset, then contention with busy_len = 2.
        //   arst v0 d0               v1 d1               t0 t1 st dn er gid addr   data
        add(0, 1, {7'h50, 8'hA5}, 0, 15'h0,          1, 0, 0, 0, 0, 0, 7'h00, 8'h00);
        add(0, 0, 15'h0,          0, 15'h0,          0, 0, 1, 0, 0, 0, 7'h50, 8'hA5);
        add(0, 0, 15'h0,          0, 15'h0,          0, 0, 0, 0, 0, 0, 7'h50, 8'hA5);
        add(0, 0, 15'h0,          0, 15'h0,          0, 0, 0, 0, 0, 0, 7'h50, 8'hA5);
        add(0, 0, 15'h0,          0, 15'h0,          0, 0, 0, 0, 0, 0, 7'h50, 8'hA5);
        add(0, 0, 15'h0,          0, 15'h0,          0, 0, 0, 1, 0, 0, 7'h50, 8'hA5);
        add(1, 0, 15'h0,          0, 15'h0,          0, 0, 0, 0, 0, 0, 7'h50, 8'hA5);
        add(0, 1, {7'h10, 8'h01}, 1, {7'h7F, 8'hFF}, 1, 0, 0, 0, 0, 0, 7'h00, 8'h00);
        add(0, 1, {7'h10, 8'h01}, 1, {7'h7F, 8'hFF}, 0, 0, 1, 0, 0, 0, 7'h10, 8'h01);
        add(0, 1, {7'h10, 8'h01}, 1, {7'h7F, 8'hFF}, 0, 0, 0, 0, 0, 0, 7'h10, 8'h01);
        add(0, 1, {7'h10, 8'h01}, 1, {7'h7F, 8'hFF}, 0, 0, 0, 0, 0, 0, 7'h10, 8'h01);
        add(0, 1, {7'h10, 8'h01}, 1, {7'h7F, 8'hFF}, 0, 0, 0, 0, 0, 0, 7'h10, 8'h01);
        add(0, 1, {7'h5A, 8'h5A}, 1, {7'h20, 8'h02}, 0, 1, 0, 1, 0, 0, 7'h10, 8'h01);
        add(0, 1, {7'h5A, 8'h5A}, 1, {7'h20, 8'h02}, 0, 0, 1, 0, 0, 1, 7'h20, 8'h02);
        add(0, 1, {7'h5A, 8'h5A}, 1, {7'h20, 8'h02}, 0, 0, 0, 0, 0, 1, 7'h20, 8'h02);
        add(0, 1, {7'h5A, 8'h5A}, 1, {7'h20, 8'h02}, 0, 0, 0, 0, 0, 1, 7'h20, 8'h02);
        add(0, 1, {7'h5A, 8'h5A}, 1, {7'h20, 8'h02}, 0, 0, 0, 0, 0, 1, 7'h20, 8'h02);
        add(0, 1, {7'h10, 8'h01}, 1, {7'h6B, 8'hC3}, 1, 0, 0, 1, 0, 1, 7'h20, 8'h02);
        add(0, 1, {7'h10, 8'h01}, 1, {7'h6B, 8'hC3}, 0, 0, 1, 0, 0, 0, 7'h10, 8'h01);
        add(0, 1, {7'h10, 8'h01}, 1, {7'h6B, 8'hC3}, 0, 0, 0, 0, 0, 0, 7'h10, 8'h01);
        add(0, 1, {7'h10, 8'h01}, 1, {7'h6B, 8'hC3}, 0, 0, 0, 0, 0, 0, 7'h10, 8'h01);
        add(0, 1, {7'h10, 8'h01}, 1, {7'h20, 8'h02}, 0, 0, 0, 0, 0, 0, 7'h10, 8'h01);
        add(0, 1, {7'h10, 8'h01}, 1, {7'h20, 8'h02}, 0, 1, 0, 1, 0, 0, 7'h10, 8'h01);
        add(0, 0, 15'h0,          0, 15'h0,          0, 0, 1, 0, 0, 1, 7'h20, 8'h02);
        add(0, 0, 15'h0,          0, 15'h0,          0, 0, 0, 0, 0, 1, 7'h20, 8'h02);
        add(0, 0, 15'h0,          0, 15'h0,          0, 0, 0, 0, 0, 1, 7'h20, 8'h02);
        add(0, 0, 15'h0,          0, 15'h0,          0, 0, 0, 0, 0, 1, 7'h20, 8'h02);
        add(0, 0, 15'h0,          0, 15'h0,          0, 0, 0, 1, 0, 1, 7'h20, 8'h02);
        add(0, 0, 15'h0,          0, 15'h0,          0, 0, 0, 0, 0, 1, 7'h20, 8'h02);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            arst      = vecs[i].in.arst;
            s0_tvalid = vecs[i].in.v0;
            s0_tdata  = vecs[i].in.d0;
            s1_tvalid = vecs[i].in.v1;
            s1_tdata  = vecs[i].in.d1;
            #1 check($sformatf("vec%0d", i), 32'(sample()), 32'(vecs[i].exp));
        end

        // Stall: engine ignores start, err after ACK_WAIT cycles in WAIT_BUSY.
        @(negedge clk); stall = 1'b1; s1_tvalid = 1'b1; s1_tdata = {7'h33, 8'h44};
        #1 check("stall_accept_s1", 32'({s0_tready, s1_tready}), 32'b01);
        @(negedge clk); s1_tvalid = 1'b0;
        #1 check("stall_start", 32'({i2c_start, grant_id, i2c_addr}), 32'({1'b1, 1'b1, 7'h33}));
        bad = 0;
        for (int c = 0; c < int'(ACK_WAIT); c++) begin
            @(negedge clk); #1;
            if (err || done) bad++;
        end
        check("stall_no_early_err", 32'(bad), 32'd0);
        @(negedge clk); stall = 1'b0;
        s0_tvalid = 1'b1; s0_tdata = {7'h0A, 8'h0B};
        s1_tvalid = 1'b1; s1_tdata = {7'h0C, 8'h0D};
        #1 check("stall_err", 32'({err, done, grant_id}), 32'b101);
        check("stall_next_grant_s0", 32'({s0_tready, s1_tready}), 32'b10);
        @(negedge clk); s0_tvalid = 1'b0; s1_tvalid = 1'b0;
        #1 check("stall_next_start", 32'({i2c_start, grant_id, i2c_addr}), 32'({1'b1, 1'b0, 7'h0A}));
        wait_done("stall_follow", 1'b0);

        // Hang: ready held low past TIMEOUT.
        @(negedge clk); busy_len = int'(TIMEOUT) + 10;
        s0_tvalid = 1'b1; s0_tdata = {7'h11, 8'h22};
        #1 check("hang_accept_s0", 32'({s0_tready, s1_tready}), 32'b10);
        @(negedge clk); s0_tvalid = 1'b0;
        #1 check("hang_start", 32'(i2c_start), 32'd1);
        bad = 0;
        for (int c = 0; c <= int'(TIMEOUT); c++) begin
            @(negedge clk); #1;
            if (err || done) bad++;
        end
        check("hang_quiet", 32'(bad), 32'd0);
        @(negedge clk); #1;
        check("hang_err", 32'({err, done, grant_id}), 32'b100);
        bad = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk); #1;
            if (done || err) bad++;
        end
        check("hang_no_done", 32'(bad), 32'd0);

        // Reset during WAIT_DONE.
        @(negedge clk); busy_len = 10;
        s1_tvalid = 1'b1; s1_tdata = {7'h45, 8'h67};
        #1 check("rst_accept_s1", 32'({s0_tready, s1_tready}), 32'b01);
        @(negedge clk); s1_tvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); arst = 1'b1;
        @(negedge clk); arst = 1'b0; busy_len = 2;
        s0_tvalid = 1'b1; s0_tdata = {7'h0E, 8'h0F};
        s1_tvalid = 1'b1; s1_tdata = {7'h7A, 8'h7B};
        #1 check("rst_outputs", 32'(sample()), 32'd0);
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            if (s0_tready || s1_tready || done || err) bad++;
        end
        check("rst_quiet_while_busy", 32'(bad), 32'd0);
        @(negedge clk); #1;
        check("rst_rr_port0", 32'({s0_tready, s1_tready}), 32'b10);
        @(negedge clk); s0_tvalid = 1'b0; s1_tvalid = 1'b0;
        #1 check("rst_next_start", 32'({i2c_start, grant_id, i2c_addr, i2c_data}),
                 32'({1'b1, 1'b0, 7'h0E, 8'h0F}));
        wait_done("rst_follow", 1'b0);

        // Busy downstream while idle.
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); force_busy = 1'b1;
            s1_tvalid = 1'b1; s1_tdata = {7'h12, 8'h34};
            #1;
            if (s1_tready || s0_tready) bad++;
        end
        check("busy_idle_no_tready", 32'(bad), 32'd0);
        @(negedge clk); force_busy = 1'b0;
        #1 check("busy_idle_release", 32'({s0_tready, s1_tready}), 32'b01);
        @(negedge clk); s1_tvalid = 1'b0;
        #1 o = sample();
        check("busy_idle_start", 32'({o.start, o.gid, o.addr, o.data}),
              32'({1'b1, 1'b1, 7'h12, 8'h34}));
        wait_done("busy_idle_follow", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_req_arbiter.md
# i2c_req_arbiter

Two-requester AXI-Stream front end for the I2C write engine (`i2c_fsm`). Accepts write commands {addr, data} on two AXI-Stream slave ports and arbitrates between them round-robin. Launches one `i2c_fsm` transaction per accepted beat, waits for completion, and reports done or timeout per transaction. Sits between the system-side command sources and the single shared `i2c_fsm` instance.

## Interface
- `ADDR_WIDTH`, 7: I2C slave address width.
- `DATA_WIDTH`, 8: payload byte width.
- `ACK_WAIT`, 4: maximum cycles to wait for `i2c_ready` to fall after `i2c_start`.
- `TIMEOUT`, 1024: maximum cycles to wait for `i2c_ready` to return high.
- `clk`  in  1  single system clock; all logic on rising edge.
- `arst`  in  1  reset; synchronous, active-high.
- `s0_tdata`, `s1_tdata`  in  ADDR_WIDTH+DATA_WIDTH  command beat, {addr[14:8], data[7:0]}.
- `s0_tvalid`, `s1_tvalid`  in  1  command valid.
- `s0_tready`, `s1_tready`  out  1  command accepted when tvalid & tready.
- `i2c_start`  out  1  one-cycle launch pulse to `i2c_fsm`.
- `i2c_addr`  out  ADDR_WIDTH  registered address for `i2c_fsm`.
- `i2c_data`  out  DATA_WIDTH  registered data for `i2c_fsm`.
- `i2c_ready`  in  1  high while `i2c_fsm` is idle.
- `done`  out  1  one-cycle pulse: transaction completed normally.
- `err`  out  1  one-cycle pulse: transaction aborted by timeout.
- `grant_id`  out  1  requester of the current/last transaction; valid with `done`/`err`.

## Operation
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- **IDLE**
  - Entry requires `i2c_ready` = 1 and at least one tvalid.
  - Pick the requester by round-robin: priority goes to the port not granted last; after reset, port 0 has priority.
  - Assert the winner's tready for exactly that cycle (handshake completes), latch tdata into `i2c_addr`/`i2c_data`, set `grant_id`, then go to LAUNCH.
  - If `i2c_ready` = 0 in IDLE, both treadys stay low.
- **LAUNCH**
  - `i2c_start` = 1 for exactly one cycle, then go to WAIT_BUSY. Clear the counter.
- **WAIT_BUSY**
  - `i2c_ready` = 0: go to WAIT_DONE and clear the counter.
  - Counter reaches ACK_WAIT: pulse `err`, go to IDLE.
- **WAIT_DONE**
  - `i2c_ready` = 1: pulse `done`, go to IDLE.
  - Counter reaches TIMEOUT: pulse `err`, go to IDLE.
- tready is never high outside IDLE. A requester's tdata may change freely while its tready is low.
- The round-robin pointer updates on every grant, regardless of done or err.
- `i2c_addr`/`i2c_data` hold their values until the next grant.

## Timing
- Reset values: all treadys 0, `i2c_start` 0, `done` 0, `err` 0, `grant_id` 0, `i2c_addr` 0, `i2c_data` 0, state IDLE, RR priority = port 0, counter 0.
- `arst` asserted in any state returns to IDLE on the next edge and drops any in-flight transaction without a `done`/`err` pulse.
- Handshake to `i2c_start`: 1 cycle (tready at cycle N, `i2c_start` at cycle N+1).
- `done` is asserted on the cycle after `i2c_ready` is sampled high in WAIT_DONE.
- Minimum accept-to-accept spacing is 4 cycles: LAUNCH, WAIT_BUSY ≥1, WAIT_DONE ≥1, IDLE.
- Counter width is clog2(max(ACK_WAIT, TIMEOUT)+1). The counter saturates and does not wrap.
- Simultaneous tvalid on both ports: exactly one handshake per grant. The loser keeps tvalid and is served next.

## Structure
- Shared package `i2c_pkg`:
  - ADDR_WIDTH/DATA_WIDTH defaults;
  - state encoding (IDLE=0, LAUNCH=1, WAIT_BUSY=2, WAIT_DONE=3);
  - tdata field offsets.
- Sub-module `rr_arb2`: a 2-way round-robin grant with priority pointer. Inputs are request[1:0] and advance; output is one-hot grant[1:0].
- Top-level integration instantiates `i2c_req_arbiter` feeding `i2c_fsm`. The bench may instead use a behavioural `i2c_fsm` model with a programmable busy length.

## Test plan
- **Single command.** Reset, then s0 sends addr 0x50, data 0xA5. Required:
  - `s0_tready` pulses once;
  - `i2c_start` pulses next cycle with `i2c_addr` 0x50 and `i2c_data` 0xA5;
  - `done` pulses with `grant_id` 0 after the model releases ready.
- **Contention.** s0 and s1 both hold valid continuously (s0: 0x10/0x01, s1: 0x20/0x02). Required: grants alternate 0,1,0,1; each beat is accepted exactly once; no tready while `i2c_ready` = 0.
- **Stall.** The model never drops `i2c_ready` after start. Required: `err` pulses ACK_WAIT cycles after WAIT_BUSY entry; next grant goes to the other port.
- **Hang.** The model holds `i2c_ready` low for TIMEOUT+10 cycles. Required: `err` after TIMEOUT cycles in WAIT_DONE; no `done` pulse.
- **Reset mid-transaction.** Assert `arst` during WAIT_DONE. Required: IDLE next cycle, all outputs at reset values, no `done`/`err`, RR priority back to port 0.
- **Busy downstream at idle.** `i2c_ready` = 0 while s1 is valid. Required: `s1_tready` stays 0 until `i2c_ready` = 1, then accepts within 1 cycle.
